iec_bus_conditioner: RTL and testbench
======================================

Name: iec_bus_conditioner

Overview:
- Parametrised N-channel conditioner for asynchronous serial-bus inputs (ATN, CLK, DATA, and optionally RESET/SRQ) feeding the drive logic.
- Replaces the fixed 3-signal double-flop, equal-for-two-samples filter with a per-channel configurable stability filter.
- Adds per-channel edge detection and edge strobes aligned to the CPU phase enable, so the VIA CA1/port logic never misses an edge between phase enables.
- Sits between the top-level bus pins and the drive's CPU/VIA complex; one instance per drive.

Parameters:
- NCH, 3, number of channels (1..8); bit 0=DATA, 1=CLK, 2=ATN by convention.
- FILT_W, 4, width of the per-channel stability counter.
- FILT_CYCLES, 2, consecutive clk32 cycles a new synchronised level must persist before acceptance; legal 1..2^FILT_W-1.
- IDLE_LEVEL, 1, reset value of all sync stages and filtered outputs (released bus reads high).

Ports:
- clk32, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- ce, input, 1, CPU phase enable (one-cycle pulse), e.g. the phase-2 falling strobe.
- bus_in, input, NCH, raw asynchronous bus levels.
- filt_out, output, NCH, filtered level, registered.
- rise, output, NCH, one-clk32 pulse coincident with the first cycle filt_out is 1 after being 0.
- fall, output, NCH, one-clk32 pulse coincident with the first cycle filt_out is 0 after being 1.
- rise_ce, output, NCH, asserted only while ce=1: a rise occurred since the previous ce, or in this cycle.
- fall_ce, output, NCH, same semantics as rise_ce for falling edges.
- glitch_clr, input, 1, clears glitch counters (see Optional Feature).
- glitch_cnt, output, 8*NCH, per-channel rejected-glitch counters; channel i occupies bits [8i+7:8i].

Behaviour:
- Clock and reset: one clock, clk32. Reset is synchronous and active-high, named reset, sampled on the rising edge of clk32.
- Reset values:
  - sync stages d1/d2 = IDLE_LEVEL on all bits.
  - filt_out = IDLE_LEVEL.
  - counters = 0; pend_rise/pend_fall = 0.
  - rise/fall = 0; rise_ce/fall_ce = 0.
  - glitch_cnt = 0.
- Synchroniser: d1 <= bus_in; d2 <= d1. Two flops per channel, no logic between them.
- Filter, per channel, every clk32 (independent of ce):
  - d2 == filt: cnt <= 0.
  - d2 != filt and cnt == FILT_CYCLES-1: filt <= d2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Latency: a clean level change on bus_in appears on filt_out exactly 2+FILT_CYCLES clk32 edges later. FILT_CYCLES=2 gives 4 clocks.
- Rejection: a d2 deviation lasting fewer than FILT_CYCLES cycles leaves filt_out unchanged and produces no edge.
- Edge pulses: rise/fall are registered on the same edge that updates filt. Each is exactly one cycle wide, and the two are never asserted together on one channel.
- ce alignment:
  - rise_ce = ce & (pend_rise | rise). Combinational from registers; fall_ce mirrors it.
  - pend_rise is set on rise and cleared on any clk32 edge where ce=1.
  - If rise and ce coincide, rise_ce=1 and pend_rise stays 0.
  - If both a rise and a fall occur between two ce pulses, rise_ce and fall_ce assert together on the next ce. filt_out gives the final level.
- Channels are fully independent; simultaneous edges on several channels are all reported in the same cycle.
- Reset mid-operation: reset forces all state to its reset value on that edge. Any in-flight count or pending edge is discarded, and no edge is reported for the return to IDLE_LEVEL.
- Illegal FILT_CYCLES (0 or > 2^FILT_W-1): elaboration error via generate-time check.

Optional Feature:
- Macro: IEC_GLITCH_CNT_EN.
- Defined: per-channel 8-bit saturating counter, incremented on each cycle where d2 == filt while cnt != 0 (a rejected glitch).
  - Saturates at 255.
  - glitch_clr=1 zeroes all counters on that edge; clear wins over a simultaneous increment.
- Undefined: no counter logic is built; glitch_cnt is tied to 0 and glitch_clr is ignored. Ports remain, so instantiations are unchanged.

Test Plan:
- Reset, NCH=3, IDLE_LEVEL=1 -> filt_out=3'b111 and all strobes 0 for all cycles while reset=1. After release with bus_in=3'b111, filt_out stays 3'b111.
- FILT_CYCLES=2, ATN (bit 2) 1->0 at clock edge 0 and held -> filt_out[2]=0 after edge 4; fall[2]=1 only in the cycle after edge 4; rise[2]=0 throughout.
- FILT_CYCLES=2, DATA low for exactly 1 cycle -> filt_out[0] stays 1 and no rise/fall. With IEC_GLITCH_CNT_EN, glitch_cnt[7:0]=1.
- ce every 32 cycles, CLK edge filtered 10 cycles after a ce -> fall_ce[1]=0 until the next ce, then 1 for exactly that ce cycle, then 0.
- ATN falls then rises, both within one ce interval -> on the next ce, rise_ce[2]=fall_ce[2]=1 and filt_out[2]=1.
- Reset asserted 1 cycle before a pending filter acceptance -> no edge reported and filt_out=IDLE_LEVEL. With IEC_GLITCH_CNT_EN, 300 glitches -> glitch_cnt=255; glitch_clr -> 0.

Source files
------------

// File: rtl/iec_bus_conditioner.sv
// N-channel serial-bus input conditioner: 2-flop synchroniser, stability filter,
// edge strobes and ce-aligned edge flags. Optional glitch counters under IEC_GLITCH_CNT_EN.
module iec_bus_conditioner #(
    parameter int unsigned NCH         = 3,
    parameter int unsigned FILT_W      = 4,
    parameter int unsigned FILT_CYCLES = 2,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic               clk32,
    input  logic               reset,
    input  logic               ce,
    input  logic [NCH-1:0]     bus_in,
    output logic [NCH-1:0]     filt_out,
    output logic [NCH-1:0]     rise,
    output logic [NCH-1:0]     fall,
    output logic [NCH-1:0]     rise_ce,
    output logic [NCH-1:0]     fall_ce,
    input  logic               glitch_clr,
    output logic [8*NCH-1:0]   glitch_cnt
);

    if (NCH == 0 || NCH > 8) begin : g_bad_nch
        $error("iec_bus_conditioner: NCH must be 1..8");
    end
    if (FILT_CYCLES == 0 || FILT_CYCLES > (2**FILT_W) - 1) begin : g_bad_filt
        $error("iec_bus_conditioner: FILT_CYCLES must be 1..2**FILT_W-1");
    end

    localparam logic [NCH-1:0]    IDLE_VEC = {NCH{IDLE_LEVEL}};
    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CYCLES - 1);

    logic [NCH-1:0]    d1_q, d2_q;
    logic [NCH-1:0]    filt_q, filt_d;
    logic [NCH-1:0]    rise_q, rise_d, fall_q, fall_d;
    logic [NCH-1:0]    pend_rise_q, pend_rise_d, pend_fall_q, pend_fall_d;
    logic [FILT_W-1:0] cnt_q [NCH];
    logic [FILT_W-1:0] cnt_d [NCH];

    always_comb begin
        filt_d = filt_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (d2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = d2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = d2_q[i];
                fall_d[i] = ~d2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + FILT_W'(1);
            end
        end
        // A strobe seen on a ce cycle is consumed there and never latched as pending.
        pend_rise_d = ce ? '0 : (pend_rise_q | rise_q);
        pend_fall_d = ce ? '0 : (pend_fall_q | fall_q);
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            d1_q        <= IDLE_VEC;
            d2_q        <= IDLE_VEC;
            filt_q      <= IDLE_VEC;
            rise_q      <= '0;
            fall_q      <= '0;
            pend_rise_q <= '0;
            pend_fall_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            d1_q        <= bus_in;
            d2_q        <= d1_q;
            filt_q      <= filt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pend_rise_q <= pend_rise_d;
            pend_fall_q <= pend_fall_d;
            for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign filt_out = filt_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign rise_ce  = {NCH{ce}} & (pend_rise_q | rise_q);
    assign fall_ce  = {NCH{ce}} & (pend_fall_q | fall_q);

`ifdef IEC_GLITCH_CNT_EN
    logic [7:0] glitch_q [NCH];
    logic [7:0] glitch_d [NCH];

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            glitch_d[i] = glitch_q[i];
            if (glitch_clr) begin
                glitch_d[i] = '0;
            end else if (d2_q[i] == filt_q[i] && cnt_q[i] != '0 && glitch_q[i] != 8'hFF) begin
                glitch_d[i] = glitch_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) glitch_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) glitch_q[i] <= glitch_d[i];
        end
    end

    always_comb begin
        glitch_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) glitch_cnt[8*i +: 8] = glitch_q[i];
    end
`else
    logic unused_glitch_clr;
    assign unused_glitch_clr = glitch_clr;
    assign glitch_cnt        = '0;
`endif

endmodule

// File: tb/tb_iec_bus_conditioner.sv
// Self-checking bench for iec_bus_conditioner (NCH=3, FILT_CYCLES=2, IDLE_LEVEL=1).
// Glitch-counter expectations follow IEC_GLITCH_CNT_EN.
module tb_iec_bus_conditioner;

`ifdef IEC_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic        clk32 = 1'b0;
    logic        reset, ce, glitch_clr;
    logic [2:0]  bus_in;
    logic [2:0]  filt_out, rise, fall, rise_ce, fall_ce;
    logic [23:0] glitch_cnt;

    always #5 clk32 = ~clk32;

    iec_bus_conditioner #(
        .NCH(3), .FILT_W(4), .FILT_CYCLES(2), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk32(clk32), .reset(reset), .ce(ce), .bus_in(bus_in),
        .filt_out(filt_out), .rise(rise), .fall(fall),
        .rise_ce(rise_ce), .fall_ce(fall_ce),
        .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
    );

    typedef struct {
        logic [2:0] bus;
        logic       ce, rst, gclr;
        logic [2:0] filt, rs, fl, rc, fc;
        int         g0;
    } vec_t;

    vec_t  tbl[$];
    vec_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    string tag      = "";

    function automatic vec_t mk(logic [2:0] bus, logic c, logic r, logic g,
                                logic [2:0] f, logic [2:0] rs, logic [2:0] fl,
                                logic [2:0] rc, logic [2:0] fc, int g0);
        vec_t v;
        v.bus = bus; v.ce = c; v.rst = r; v.gclr = g;
        v.filt = f; v.rs = rs; v.fl = fl; v.rc = rc; v.fc = fc; v.g0 = g0;
        return v;
    endfunction

    task automatic add(int n, logic [2:0] bus, logic c, logic [2:0] f, logic [2:0] rs,
                       logic [2:0] fl, logic [2:0] rc, logic [2:0] fc, int g0);
        repeat (n) tbl.push_back(mk(bus, c, 1'b0, 1'b0, f, rs, fl, rc, fc, g0));
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] %s: got %h expected %h", tag, cyc, nm, act, exp);
        end
    endtask

    task automatic step(vec_t v);
        vec_t e;
        logic [23:0] eg;
        bus_in = v.bus; ce = v.ce; reset = v.rst; glitch_clr = v.gclr;
        sb.push_back(v);
        @(negedge clk32);
        e  = sb.pop_front();
        eg = GC_EN ? {16'h0, 8'(e.g0)} : 24'h0;
        chk("filt_out",   {29'd0, filt_out}, {29'd0, e.filt});
        chk("rise",       {29'd0, rise},     {29'd0, e.rs});
        chk("fall",       {29'd0, fall},     {29'd0, e.fl});
        chk("rise_ce",    {29'd0, rise_ce},  {29'd0, e.rc});
        chk("fall_ce",    {29'd0, fall_ce},  {29'd0, e.fc});
        chk("glitch_cnt", {8'd0, glitch_cnt}, {8'd0, eg});
        @(posedge clk32);
        #1;
        cyc++;
    endtask

    task automatic drive(logic [2:0] bus);
        bus_in = bus; ce = 1'b0; reset = 1'b0; glitch_clr = 1'b0;
        @(posedge clk32);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ce = 1'b0; bus_in = 3'b000; glitch_clr = 1'b0;
        @(posedge clk32);
        #1;

        // Reset holds idle level and quiet strobes even with bus low and ce active.
        tag = "reset"; cyc = 0;
        repeat (3) step(mk(3'b000, 1, 1, 0, 3'b111, 0, 0, 0, 0, 0));

        //   n  bus     ce filt    rise    fall    rise_ce fall_ce g0
        add(1, 3'b111, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(1, 3'b111, 1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(4, 3'b011, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(1, 3'b011, 0, 3'b011, 3'b000, 3'b100, 3'b000, 3'b000, 0);
        add(1, 3'b011, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(1, 3'b011, 1, 3'b011, 3'b000, 3'b000, 3'b000, 3'b100, 0);
        add(1, 3'b011, 1, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(1, 3'b010, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(3, 3'b011, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(1, 3'b011, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(2, 3'b010, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(2, 3'b011, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b011, 0, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 1);
        add(1, 3'b011, 0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b011, 0, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b011, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b011, 1, 3'b011, 3'b000, 3'b000, 3'b001, 3'b001, 1);
        add(1, 3'b011, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(4, 3'b111, 0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b111, 1, 3'b111, 3'b100, 3'b000, 3'b100, 3'b000, 1);
        add(1, 3'b111, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b111, 1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(4, 3'b000, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b000, 0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1);
        add(1, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(4, 3'b111, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b111, 0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b111, 1, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 1);
        add(1, 3'b111, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1);

        tag = "table"; cyc = 0;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // ATN falls and rises back inside one ce interval.
        tag = "atn_pulse"; cyc = 0;
        for (int c = 0; c < 10; c++)
            step(mk((c < 2) ? 3'b011 : 3'b111, c == 8, 0, 0,
                    (c == 4 || c == 5) ? 3'b011 : 3'b111,
                    (c == 6) ? 3'b100 : 3'b000, (c == 4) ? 3'b100 : 3'b000,
                    (c == 8) ? 3'b100 : 3'b000, (c == 8) ? 3'b100 : 3'b000, 1));

        // ce every 32 cycles; CLK fall lands 10 cycles after a ce.
        tag = "clk_ce32"; cyc = 0;
        for (int c = 0; c < 64; c++)
            step(mk((c >= 6) ? 3'b101 : 3'b111, (c % 32) == 0, 0, 0,
                    (c >= 10) ? 3'b101 : 3'b111, 3'b000,
                    (c == 10) ? 3'b010 : 3'b000, 3'b000,
                    (c == 32) ? 3'b010 : 3'b000, 1));
        for (int c = 64; c < 72; c++)
            step(mk(3'b111, c == 70, 0, 0, (c >= 68) ? 3'b111 : 3'b101,
                    (c == 68) ? 3'b010 : 3'b000, 3'b000,
                    (c == 70) ? 3'b010 : 3'b000, 3'b000, 1));

        // Reset one cycle before ATN acceptance, with a DATA fall still pending.
        tag = "reset_mid"; cyc = 0;
        for (int c = 0; c < 12; c++)
            step(mk((c < 3) ? 3'b110 : (c < 6) ? 3'b010 : 3'b111, c == 7, c == 5, 0,
                    (c == 4 || c == 5) ? 3'b110 : 3'b111, 3'b000,
                    (c == 4) ? 3'b001 : 3'b000, 3'b000, 3'b000, (c < 6) ? 1 : 0));

        // 300 single-cycle DATA glitches saturate the counter.
        tag = "glitch_sat"; cyc = 0;
        for (int k = 0; k < 300; k++) begin
            drive(3'b110);
            drive(3'b111);
            drive(3'b111);
        end
        drive(3'b111);
        step(mk(3'b111, 0, 0, 0, 3'b111, 0, 0, 0, 0, 255));
        step(mk(3'b111, 0, 0, 1, 3'b111, 0, 0, 0, 0, 255));
        step(mk(3'b111, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));

        // One counted glitch, then a clear on the same edge as an increment.
        tag = "glitch_clr"; cyc = 0;
        step(mk(3'b110, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
        repeat (3) step(mk(3'b111, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
        step(mk(3'b111, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1));
        step(mk(3'b110, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1));
        repeat (2) step(mk(3'b111, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1));
        step(mk(3'b111, 0, 0, 1, 3'b111, 0, 0, 0, 0, 1));
        repeat (2) step(mk(3'b111, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
